// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand bypass selects, load-use/branch stalls and an MDU busy FSM.
// Define HAZARD_PERF_CNT_EN to add the 32-bit stall_cycles counter output.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic       regwriteE,
    input  logic       memtoregE,
    input  logic       branchD,
    input  logic       mdu_startE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteM,
    input  logic       memtoregM,
    input  logic       regwriteW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushE,
    output logic       mdu_busy,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [3:0] CntInit = 4'(MDU_LAT - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lwstall;
    logic       branchstall;

    // $zero is hardwired, so it never produces a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_comb begin
        forwardAE = 2'b00;
        if (regwriteM && reg_match(writeregM, rsE)) begin
            forwardAE = 2'b10;
        end else if (regwriteW && reg_match(writeregW, rsE)) begin
            forwardAE = 2'b01;
        end

        forwardBE = 2'b00;
        if (regwriteM && reg_match(writeregM, rtE)) begin
            forwardBE = 2'b10;
        end else if (regwriteW && reg_match(writeregW, rtE)) begin
            forwardBE = 2'b01;
        end

        forwardAD = regwriteM && reg_match(writeregM, rsD);
        forwardBD = regwriteM && reg_match(writeregM, rtD);

        lwstall = memtoregE && (reg_match(rtE, rsD) || reg_match(rtE, rtD));

        branchstall = branchD &&
            ((regwriteE && (reg_match(writeregE, rsD) || reg_match(writeregE, rtD))) ||
             (memtoregM && (reg_match(writeregM, rsD) || reg_match(writeregM, rtD))));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (mdu_startE) begin
                    state_d = StBusy;
                    cnt_d   = CntInit;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        mdu_busy = (state_q == StBusy);
        stallE   = mdu_busy;
        stallF   = lwstall || branchstall || mdu_busy;
        stallD   = stallF;
        // A frozen Execute stage must keep its contents, so never flush it.
        flushE   = (lwstall || branchstall) && !mdu_busy;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallD) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
